// File: rtl/vga_write_scheduler.sv
// Two-requester pixel-write arbiter with a full-screen clear engine driving one VGA SRAM write port.
// Grants are registered; the captured request is written (or flagged out of range) on the following cycle.
module vga_write_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned SCR_W     = 640,
  parameter int unsigned SCR_H     = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [9:0]  y0,
  input  logic [9:0]  y1,
  input  logic [7:0]  color0,
  input  logic [7:0]  color1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        clear_start,
  input  logic [7:0]  clear_color,
  output logic        busy,
  output logic        clear_done,
  output logic        range_err,
  output logic        vga_sram_write,
  output logic [31:0] vga_sram_address,
  output logic [7:0]  vga_sram_writedata
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e      state_q, state_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        rr_q, rr_d;
  logic [9:0]  cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [7:0]  cap_c_q, cap_c_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d;
  logic        fill_end_q, fill_end_d;
  logic [7:0]  fill_c_q, fill_c_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        pend, in_range, el0, el1, pick1;
  logic [9:0]  cx_nxt, cy_nxt;
  logic        at_last;

  function automatic logic [31:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return BASE_ADDR + {22'd0, x} + ({22'd0, y} * SCR_W);
  endfunction

  always_comb begin
    cx_nxt  = cx_q + 10'd1;
    cy_nxt  = cy_q;
    at_last = 1'b0;
    if (cx_q == 10'(SCR_W - 1)) begin
      cx_nxt = '0;
      if (cy_q == 10'(SCR_H - 1)) begin
        cy_nxt  = '0;
        at_last = 1'b1;
      end else begin
        cy_nxt = cy_q + 10'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rr_d       = rr_q;
    cap_x_d    = cap_x_q;
    cap_y_d    = cap_y_q;
    cap_c_d    = cap_c_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    fill_end_d = fill_end_q;
    fill_c_d   = fill_c_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pick1      = 1'b0;

    pend     = gnt0_q | gnt1_q;
    in_range = ({22'd0, cap_x_q} < SCR_W) && ({22'd0, cap_y_q} < SCR_H);
    // A requester's data is still the granted one on the gnt cycle, so it is masked then.
    el0      = req0 & ~gnt0_q;
    el1      = req1 & ~gnt1_q;

    if (pend) begin
      if (in_range) begin
        wr_d   = 1'b1;
        addr_d = pix_addr(cap_x_q, cap_y_q);
        data_d = cap_c_q;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // clear_start is only accepted when no granted write is still in flight,
        // since the first fill write would otherwise collide with it on the port.
        if (clear_start) begin
          if (!pend) begin
            state_d    = CLEAR;
            busy_d     = 1'b1;
            fill_c_d   = clear_color;
            wr_d       = 1'b1;
            addr_d     = pix_addr(cx_q, cy_q);
            data_d     = clear_color;
            cx_d       = cx_nxt;
            cy_d       = cy_nxt;
            fill_end_d = at_last;
          end
        end else if (el0 | el1) begin
          pick1   = el1 & (~el0 | rr_q);
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          rr_d    = ~pick1;
          cap_x_d = pick1 ? x1 : x0;
          cap_y_d = pick1 ? y1 : y0;
          cap_c_d = pick1 ? color1 : color0;
        end
      end
      CLEAR: begin
        if (fill_end_q) begin
          fill_end_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          wr_d       = 1'b1;
          addr_d     = pix_addr(cx_q, cy_q);
          data_d     = fill_c_q;
          cx_d       = cx_nxt;
          cy_d       = cy_nxt;
          fill_end_d = at_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rr_q       <= 1'b0;
      cap_x_q    <= '0;
      cap_y_q    <= '0;
      cap_c_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      fill_end_q <= 1'b0;
      fill_c_q   <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rr_q       <= rr_d;
      cap_x_q    <= cap_x_d;
      cap_y_q    <= cap_y_d;
      cap_c_q    <= cap_c_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      fill_end_q <= fill_end_d;
      fill_c_q   <= fill_c_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign gnt0               = gnt0_q;
  assign gnt1               = gnt1_q;
  assign busy               = busy_q;
  assign clear_done         = done_q;
  assign range_err          = err_q;
  assign vga_sram_write     = wr_q;
  assign vga_sram_address   = addr_q;
  assign vga_sram_writedata = data_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Scoreboard bench for vga_write_scheduler: a cycle-level behavioural model queues expected
// grants, writes and clear_done pulses; a negedge monitor pops and compares what the DUT shows.
module tb_vga_write_scheduler;

  localparam int unsigned W    = 640;
  localparam int unsigned H    = 4;
  localparam int unsigned N    = W * H;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock, reset;
  logic        req0, req1, gnt0, gnt1;
  logic [9:0]  x0, x1, y0, y1;
  logic [7:0]  color0, color1, clear_color;
  logic        clear_start, busy, clear_done, range_err;
  logic        vga_sram_write;
  logic [31:0] vga_sram_address;
  logic [7:0]  vga_sram_writedata;

  vga_write_scheduler #(.BASE_ADDR(BASE), .SCR_W(W), .SCR_H(H)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .color0(color0), .color1(color1), .gnt0(gnt0), .gnt1(gnt1),
    .clear_start(clear_start), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done), .range_err(range_err),
    .vga_sram_write(vga_sram_write), .vga_sram_address(vga_sram_address),
    .vga_sram_writedata(vga_sram_writedata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { int cyc; logic err; logic [31:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; int id; } gn_t;

  wr_t wq[$];
  gn_t gq[$];
  int  dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_last = 1;
  int m_prev = -1;
  int m_gnt_now = -1;
  bit m_clr = 1'b0;
  int m_clr_end = 0;
  int busy_lo = 1;
  int busy_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference: who is granted each cycle, and which pixels land where and when.
  always @(posedge clock) begin
    int g;
    bit e0, e1;
    int unsigned xx, yy;
    logic [7:0] cc;
    cyc++;
    g = -1;
    if (!reset) begin
      wq.delete(); gq.delete(); dq.delete();
      m_last = 1; m_prev = -1; m_gnt_now = -1; m_clr = 1'b0;
      busy_lo = 1; busy_hi = 0;
    end else begin
      if (m_clr && cyc > m_clr_end) m_clr = 1'b0;
      if (!m_clr && clear_start) begin
        if (m_prev < 0) begin
          m_clr = 1'b1;
          m_clr_end = cyc + N;
          busy_lo = cyc;
          busy_hi = cyc + N - 1;
          for (int i = 0; i < int'(N); i++)
            wq.push_back('{cyc + i, 1'b0, BASE + 32'(i), clear_color});
          dq.push_back(cyc + N);
        end
      end else if (!m_clr) begin
        e0 = req0 && (m_prev != 0);
        e1 = req1 && (m_prev != 1);
        if (e0 && e1) g = (m_last == 0) ? 1 : 0;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        if (g >= 0) begin
          xx = (g == 0) ? x0 : x1;
          yy = (g == 0) ? y0 : y1;
          cc = (g == 0) ? color0 : color1;
          gq.push_back('{cyc, g});
          if (xx < W && yy < H) wq.push_back('{cyc + 1, 1'b0, BASE + xx + yy * W, cc});
          else                  wq.push_back('{cyc + 1, 1'b1, 32'd0, 8'd0});
          m_last = g;
        end
      end
      m_prev = g;
      m_gnt_now = g;
    end
  end

  always @(negedge clock) begin
    gn_t ge;
    wr_t we;
    int  de;
    if (!reset) begin
      chk("reset_outputs", {vga_sram_address, vga_sram_writedata, gnt0, gnt1, vga_sram_write,
          busy, clear_done, range_err} == '0, 32'd1);
    end else begin
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) chk("unexpected_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        else begin
          ge = gq.pop_front();
          chk("gnt_cycle", cyc, ge.cyc);
          chk("gnt_id", {30'd0, gnt1, gnt0}, (ge.id == 0) ? 32'd1 : 32'd2);
        end
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        ge = gq.pop_front();
        chk("missed_gnt_cycle", 32'(ge.cyc), 32'(cyc));
      end
      if (vga_sram_write || range_err) begin
        if (wq.size() == 0) chk("unexpected_write", {30'd0, range_err, vga_sram_write}, 32'd0);
        else begin
          we = wq.pop_front();
          chk("write_cycle", cyc, we.cyc);
          chk("write_kind", {30'd0, range_err, vga_sram_write}, we.err ? 32'd2 : 32'd1);
          if (!we.err) begin
            chk("write_addr", vga_sram_address, we.addr);
            chk("write_data", {24'd0, vga_sram_writedata}, {24'd0, we.data});
          end
        end
      end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        we = wq.pop_front();
        chk("missed_write_cycle", 32'(we.cyc), 32'(cyc));
      end
      if (clear_done) begin
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          de = dq.pop_front();
          chk("done_cycle", cyc, de);
        end
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        de = dq.pop_front();
        chk("missed_done_cycle", 32'(de), 32'(cyc));
      end
      chk("busy", {31'd0, busy}, (cyc >= busy_lo && cyc <= busy_hi) ? 32'd1 : 32'd0);
    end
  end

  function automatic logic [9:0] rand_x();
    return ($urandom_range(0, 9) == 0) ? 10'($urandom_range(W, 1023)) : 10'($urandom_range(0, W - 1));
  endfunction

  function automatic logic [9:0] rand_y();
    return ($urandom_range(0, 9) == 0) ? 10'($urandom_range(H, 1023)) : 10'($urandom_range(0, H - 1));
  endfunction

  task automatic rand_cycle();
    @(negedge clock);
    clear_start = 1'b0;
    if (!req0 || m_gnt_now == 0) begin
      req0 = ($urandom_range(0, 99) < 55); x0 = rand_x(); y0 = rand_y(); color0 = 8'($urandom);
    end
    if (!req1 || m_gnt_now == 1) begin
      req1 = ($urandom_range(0, 99) < 55); x1 = rand_x(); y1 = rand_y(); color1 = 8'($urandom);
    end
    if ($urandom_range(0, 1999) == 0) begin
      clear_start = 1'b1; clear_color = 8'($urandom);
    end
  endtask

  task automatic wait_gnt(input int id, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (m_gnt_now != id && n < limit);
    chk("wait_gnt_timeout", 32'(m_gnt_now), 32'(id));
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic quiet();
    int n;
    n = 0;
    @(negedge clock);
    req0 = 1'b0; req1 = 1'b0; clear_start = 1'b0;
    while (m_clr && n < int'(N) + 10) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; clear_start = 1'b0; clear_color = '0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color0 = '0; color1 = '0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;

    // Contention straight after reset: pointer favours req0, then alternates.
    @(negedge clock);
    req0 = 1'b1; x0 = 10'd1; y0 = 10'd0; color0 = 8'h10;
    req1 = 1'b1; x1 = 10'd2; y1 = 10'd1; color1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("contention_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("contention_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (m_gnt_now == 0) begin x0 = x0 + 10'd3; color0 = color0 + 8'd1; end
      if (m_gnt_now == 1) begin x1 = x1 + 10'd5; color1 = color1 + 8'd1; end
    end
    req0 = 1'b0; req1 = 1'b0;

    @(negedge clock);
    req0 = 1'b1; x0 = 10'd5; y0 = 10'd2; color0 = 8'hFF;
    wait_gnt(0, 10);
    @(negedge clock);
    chk("single_write", {31'd0, vga_sram_write}, 32'd1);
    chk("single_addr", vga_sram_address, 32'd1285);
    chk("single_data", {24'd0, vga_sram_writedata}, 32'h0000_00FF);

    req1 = 1'b1; x1 = 10'd640; y1 = 10'd0; color1 = 8'h33;
    wait_gnt(1, 10);
    @(negedge clock);
    chk("range_err_pulse", {31'd0, range_err}, 32'd1);
    chk("range_no_write", {31'd0, vga_sram_write}, 32'd0);
    req1 = 1'b1; x1 = 10'd639; y1 = 10'(H - 1); color1 = 8'h5A;
    wait_gnt(1, 10);
    @(negedge clock);
    // last pixel of the reduced 640x4 screen: 639 + 3*640
    chk("last_pixel_addr", vga_sram_address, 32'd2559);

    for (int i = 0; i < 4000; i++) rand_cycle();
    quiet();

    // Clear while req0 waits: no grant until the cycle after clear_done.
    @(negedge clock);
    clear_start = 1'b1; clear_color = 8'h00;
    req0 = 1'b1; x0 = 10'd7; y0 = 10'd1; color0 = 8'h55;
    @(negedge clock);
    clear_start = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd1);
    chk("clear_no_gnt0", {31'd0, gnt0}, 32'd0);
    wait_gnt(0, int'(N) + 20);
    quiet();

    @(negedge clock);
    clear_start = 1'b1; clear_color = 8'h96;
    req1 = 1'b1; x1 = 10'd3; y1 = 10'd3; color1 = 8'h11;
    @(negedge clock);
    clear_start = 1'b0;
    chk("clear_req1_no_gnt1", {31'd0, gnt1}, 32'd0);
    chk("clear_req1_busy", {31'd0, busy}, 32'd1);
    repeat (500) @(negedge clock);
    clear_start = 1'b1; clear_color = 8'hAB;
    @(negedge clock);
    clear_start = 1'b0;
    wait_gnt(1, int'(N) + 20);
    quiet();

    // Abort a fill with reset partway through.
    @(negedge clock);
    clear_start = 1'b1; clear_color = 8'h3C;
    @(negedge clock);
    clear_start = 1'b0;
    repeat (999) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("abort_outputs_zero", {vga_sram_address, vga_sram_writedata, gnt0, gnt1, vga_sram_write,
          busy, clear_done, range_err} == '0, 32'd1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    req0 = 1'b1; x0 = 10'd10; y0 = 10'd0; color0 = 8'h77;
    wait_gnt(0, 10);
    @(negedge clock);
    chk("post_abort_write", {31'd0, vga_sram_write}, 32'd1);
    chk("post_abort_addr", vga_sram_address, 32'd10);

    repeat (5) @(negedge clock);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_write_scheduler.md
VGA_WRITE_SCHEDULER -- requirements
Module: vga_write_scheduler

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, VGA pixel buffer base address.
REQ-002 Parameter SCR_W, 640, screen width in pixels.
REQ-003 Parameter SCR_H, 480, screen height in pixels.
REQ-004 clock  in  1  system clock (CLOCK_50 domain); all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req0, req1  in  1 each  pixel-write requests from requester 0 and requester 1.
REQ-007 x0, x1  in  10 each  pixel column for requester 0 and requester 1.
REQ-008 y0, y1  in  10 each  pixel row for requester 0 and requester 1.
REQ-009 color0, color1  in  8 each  pixel colour for requester 0 and requester 1.
REQ-010 gnt0, gnt1  out  1 each  one-cycle grant; request data is captured on this cycle.
REQ-011 clear_start  in  1  pulse that starts a full-screen fill.
REQ-012 clear_color  in  8  fill colour, sampled on the accepted clear_start cycle.
REQ-013 busy  out  1  high while the clear engine is active.
REQ-014 clear_done  out  1  one-cycle pulse after the last fill write.
REQ-015 range_err  out  1  one-cycle pulse when a granted request has out-of-range coordinates.
REQ-016 vga_sram_write, vga_sram_address, vga_sram_writedata  out  1/32/8  VGA SRAM write port.

Function
REQ-017 States SHALL be: IDLE (arbitrate) and CLEAR (fill); every output SHALL be registered.
REQ-018 IDLE, one or more reqN high, clear_start low: exactly one gnt SHALL pulse for one cycle, capturing xN, yN and colorN.
REQ-019 Requester handshake: hold reqN and its data stable until gntN is seen; drop reqN or present new data on the following cycle.
REQ-020 Both requests high: the requester not granted last SHALL win (round-robin); after reset the pointer SHALL favour req0.
REQ-021 Only one request high: that requester SHALL be granted regardless of the pointer.
REQ-022 A grant on cycle t SHALL produce vga_sram_write=1 for exactly one cycle at t+1.
REQ-023 The write address SHALL be BASE_ADDR + x + y*SCR_W, computed at 32 bits with zero-extended operands; data SHALL be the captured colour.
REQ-024 Back-to-back grants on consecutive cycles SHALL be supported: sustained throughput is one write per cycle.
REQ-025 Coordinates x>=SCR_W or y>=SCR_H: the request SHALL still be granted, vga_sram_write SHALL stay 0 at t+1, and range_err SHALL pulse at t+1.
REQ-026 clear_start high in IDLE SHALL move the block to CLEAR, latch clear_color, and assert busy from the next cycle; no grant SHALL issue that cycle, even if requests are pending.
REQ-027 CLEAR behaviour:
- one write per cycle, raster order (x fastest), addresses BASE_ADDR through BASE_ADDR+SCR_W*SCR_H-1;
- the first write SHALL occur on the cycle after clear_start.
REQ-028 CLEAR: gnt0 and gnt1 SHALL stay 0, and requests SHALL remain pending.
REQ-029 clear_start during CLEAR SHALL be ignored: no restart and no colour change.
REQ-030 After the write to (SCR_W-1, SCR_H-1):
- clear_done SHALL pulse on the next cycle;
- busy SHALL deassert on that same cycle;
- the state SHALL return to IDLE, and arbitration SHALL resume on that cycle.
REQ-031 The x and y counters SHALL wrap: x to 0 with y+1 at SCR_W-1; the engine SHALL terminate at y=SCR_H-1, with no wrap past the screen.

Reset
REQ-032 While reset is low, the following SHALL be 0: gnt0, gnt1, vga_sram_write, vga_sram_address, vga_sram_writedata, busy, clear_done and range_err.
REQ-033 While reset is low, the state SHALL be IDLE, the counters SHALL be 0, and the round-robin pointer SHALL favour req0.
REQ-034 Reset asserted mid-CLEAR or mid-write SHALL abort the operation immediately, with no clear_done pulse and no further writes.
REQ-035 Deasserting reset SHALL return the block to IDLE.

Verification
REQ-036 Single request: req0, x0=5, y0=2, color0=8'hFF -> gnt0 pulses at t; at t+1 write=1, address=32'd1285, data=8'hFF.
REQ-037 Contention: req0 and req1 held high for 4 cycles -> grants alternate gnt0, gnt1, gnt0, gnt1, giving 4 consecutive writes.
REQ-038 Range check: req1, x1=640, y1=0 -> gnt1 pulses and range_err pulses at t+1 with no write; x1=639, y1=479 -> address 307199.
REQ-039 Clear: clear_start with clear_color=8'h00 while req0 is held ->
- 307200 writes, addresses 0 to 307199, all data 8'h00;
- no gnt0 during the fill; clear_done pulses once;
- gnt0 on the cycle after clear_done.
REQ-040 Abort: reset driven low at clear write 1000 -> all outputs 0 at once; no clear_done; after release, req0 is granted normally.
REQ-041 Contention with clear: clear_start and req1 on the same cycle -> no gnt1 that cycle; busy=1 next cycle; a second clear_start mid-fill has no effect.
